// File: rtl/special_alu_pkg.sv
// special_alu_pkg: operation codes, response error codes, master FSM states
// and the operand-count helper shared by special_alu and special_alu_master.
package special_alu_pkg;

  // ALU operation codes
  localparam logic [2:0] OP_ADD2 = 3'd0;
  localparam logic [2:0] OP_SUB2 = 3'd1;
  localparam logic [2:0] OP_OR2  = 3'd2;
  localparam logic [2:0] OP_AND2 = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_SUM  = 3'd6;
  localparam logic [2:0] OP_AVG  = 3'd7;

  // Response error codes
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_UNDER   = 2'd1;
  localparam logic [1:0] ERR_FULL    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Highest op code that consumes two operands
  localparam logic [2:0] NEED2_MAX_OP = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PUSH,
    ST_EXEC,
    ST_RESP
  } state_t;

  // Minimum FIFO occupancy an operation needs before it may be issued
  function automatic logic [3:0] need_count(input logic [2:0] op);
    return (op <= NEED2_MAX_OP) ? 4'd2 : 4'd1;
  endfunction

endpackage

// File: rtl/special_alu_wdog.sv
// special_alu_wdog: loadable down-counter used as the execute watchdog.
// clear has priority over load, load over enable; expired flags a zero count.
module special_alu_wdog #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         expired
);

  logic [W-1:0] count;

  // Count down from the loaded value while enabled, stopping at zero
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/special_alu_master.sv
// special_alu_master: command-driven initiator for the special_alu A (operand)
// and B (result) interfaces. Mirrors ALU FIFO occupancy to reject pushes into
// a full FIFO and executes with too few operands, and returns one response
// per accepted command.
// Optional watchdog on execute: define SPECIAL_ALU_MASTER_TIMEOUT_EN.
module special_alu_master
  import special_alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int DEPTH          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_exec,
  input  logic [7:0]  cmd_data,
  input  logic [2:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [10:0] rsp_result,
  output logic [1:0]  rsp_err,
  output logic        a_valid,
  output logic [7:0]  a_operand,
  input  logic        a_ready,
  output logic [2:0]  b_operation,
  output logic        b_ready,
  input  logic        b_valid,
  input  logic [10:0] b_result
);

  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  state_t      state, state_d;
  logic [3:0]  occ, occ_d;
  logic [7:0]  operand_d;
  logic [2:0]  op_d;
  logic [10:0] result_d;
  logic [1:0]  err_d;
  logic        timeout;

`ifdef SPECIAL_ALU_MASTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

  logic wd_expired;

  // Reloaded while idle, counts down once per EXEC cycle; the last allowed
  // EXEC cycle is the one where the count reaches zero.
  special_alu_wdog #(
    .W (WD_W)
  ) u_wdog (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == ST_RESP),
    .load       (state == ST_IDLE),
    .load_value (WD_LOAD),
    .enable     (state == ST_EXEC),
    .expired    (wd_expired)
  );

  assign timeout = (state == ST_EXEC) && wd_expired;
`else
  // The watchdog limit only matters when the watchdog is built
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout            = 1'b0;
`endif

  // State, occupancy mirror and latched command/response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      occ         <= '0;
      a_operand   <= '0;
      b_operation <= '0;
      rsp_result  <= '0;
      rsp_err     <= ERR_OK;
    end else begin
      state       <= state_d;
      occ         <= occ_d;
      a_operand   <= operand_d;
      b_operation <= op_d;
      rsp_result  <= result_d;
      rsp_err     <= err_d;
    end
  end

  // Next-state: classify commands, run the A or B handshake, hold the response
  always_comb begin
    // NOTE: every variable gets a hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d   = state;
    occ_d     = occ;
    operand_d = a_operand;
    op_d      = b_operation;
    result_d  = rsp_result;
    err_d     = rsp_err;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          result_d = '0;
          err_d    = ERR_OK;
          if (!cmd_exec) begin
            if (occ == DEPTH_L) begin
              err_d   = ERR_FULL;
              state_d = ST_RESP;
            end else begin
              // Operand only reaches the ALU pins for a push that will issue
              operand_d = cmd_data;
              state_d   = ST_PUSH;
            end
          end else if (occ < need_count(cmd_op)) begin
            err_d   = ERR_UNDER;
            state_d = ST_RESP;
          end else begin
            op_d    = cmd_op;
            state_d = ST_EXEC;
          end
        end
      end

      ST_PUSH: begin
        if (a_ready) begin
          occ_d    = occ + 4'd1;
          result_d = '0;
          err_d    = ERR_OK;
          state_d  = ST_RESP;
        end
      end

      ST_EXEC: begin
        // A result arriving in the final watchdog cycle still wins
        if (b_valid) begin
          result_d = b_result;
          occ_d    = occ - 4'd1;
          err_d    = ERR_OK;
          state_d  = ST_RESP;
        end else if (timeout) begin
          result_d = '0;
          err_d    = ERR_TIMEOUT;
          state_d  = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // A and B sides are never active together: the ALU folds b_ready into a_ready
  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign a_valid   = (state == ST_PUSH);
  assign b_ready   = (state == ST_EXEC);

endmodule

// File: tb/tb_special_alu_master.sv
// Bench for special_alu_master: a behavioural special_alu stand-in (operand
// queue, one entry consumed per execute), directed scenarios plus random
// commands, and a scoreboard fed at issue time and drained by a monitor.
// Timeout scenario is built when SPECIAL_ALU_MASTER_TIMEOUT_EN is defined.
module tb_special_alu_master;
  import special_alu_pkg::*;

  localparam int TB_DEPTH   = 8;
  localparam int TB_TIMEOUT = 16;

  typedef struct packed {
    logic [10:0] result;
    logic [1:0]  err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_exec;
  logic [7:0]  cmd_data;
  logic [2:0]  cmd_op;
  logic        rsp_valid, rsp_ready;
  logic [10:0] rsp_result;
  logic [1:0]  rsp_err;
  logic        a_valid, a_ready;
  logic [7:0]  a_operand;
  logic [2:0]  b_operation;
  logic        b_ready, b_valid;
  logic [10:0] b_result;

  logic a_ready_en;
  logic b_valid_en;

  int   alu_q[$];
  int   ref_q[$];
  rsp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  special_alu_master #(
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .DEPTH          (TB_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_exec    (cmd_exec),
    .cmd_data    (cmd_data),
    .cmd_op      (cmd_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_err     (rsp_err),
    .a_valid     (a_valid),
    .a_operand   (a_operand),
    .a_ready     (a_ready),
    .b_operation (b_operation),
    .b_ready     (b_ready),
    .b_valid     (b_valid),
    .b_result    (b_result)
  );

  // The ALU accepts operands whenever b_ready is high as well
  assign a_ready = a_ready_en | b_ready;
  assign b_valid = b_valid_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of an operation over the current operand queue (oldest first)
  function automatic int alu_fn(input logic [2:0] op, input int q[$]);
    int acc;
    acc = 0;
    if (q.size() == 0) return 0;
    if (op <= NEED2_MAX_OP && q.size() < 2) return 0;
    case (op)
      OP_ADD2: acc = q[0] + q[1];
      OP_SUB2: acc = q[0] - q[1];
      OP_OR2:  acc = q[0] | q[1];
      OP_AND2: acc = q[0] & q[1];
      OP_OR:   foreach (q[i]) acc = acc | q[i];
      OP_AND:  begin acc = 255; foreach (q[i]) acc = acc & q[i]; end
      OP_SUM:  foreach (q[i]) acc = acc + q[i];
      default: begin foreach (q[i]) acc = acc + q[i]; acc = acc / q.size(); end
    endcase
    return acc & 32'h7FF;
  endfunction

  // ALU stand-in: operand FIFO updated on handshakes
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        alu_q.delete();
      end else if (a_valid && a_ready) begin
        alu_q.push_back(int'(a_operand));
      end else if (b_valid && b_ready && alu_q.size() > 0) begin
        void'(alu_q.pop_front());
      end
    end
  end

  // ALU stand-in: result presented half a cycle ahead of the next edge
  initial begin
    b_result = '0;
    forever begin
      @(negedge clk);
      b_result = 11'(alu_fn(b_operation, alu_q));
    end
  end

  // Monitor: compare every response handshake against the scoreboard
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected response", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_result", 32'(rsp_result), 32'(e.result));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, " cmd_ready"},   32'(cmd_ready),   32'd1);
    check({tag, " rsp_valid"},   32'(rsp_valid),   32'd0);
    check({tag, " rsp_result"},  32'(rsp_result),  32'd0);
    check({tag, " rsp_err"},     32'(rsp_err),     32'd0);
    check({tag, " a_valid"},     32'(a_valid),     32'd0);
    check({tag, " a_operand"},   32'(a_operand),   32'd0);
    check({tag, " b_ready"},     32'(b_ready),     32'd0);
    check({tag, " b_operation"}, 32'(b_operation), 32'd0);
  endtask

  // Issue one command, predict its response, and follow it to completion
  task automatic send(input bit ex, input logic [7:0] d, input logic [2:0] op,
                      input int a_stall, input int rsp_stall, input bit expect_timeout);
    rsp_t e;
    int   exp_lat;
    int   lat;
    bit   rej;
    bit   to_push;
    int   need;

    e.result = '0;
    e.err    = ERR_OK;
    rej      = 1'b0;
    to_push  = 1'b0;
    need     = (op <= NEED2_MAX_OP) ? 2 : 1;
    if (!ex) begin
      if (ref_q.size() >= TB_DEPTH) begin
        e.err = ERR_FULL;
        rej   = 1'b1;
      end else begin
        ref_q.push_back(int'(d));
        to_push = 1'b1;
      end
    end else if (ref_q.size() < need) begin
      e.err = ERR_UNDER;
      rej   = 1'b1;
    end else if (expect_timeout) begin
      e.err = ERR_TIMEOUT;
    end else begin
      e.result = 11'(alu_fn(op, ref_q));
      void'(ref_q.pop_front());
    end
    exp_lat = rej ? 1 : (to_push && a_stall > 0) ? a_stall + 1 :
              expect_timeout ? TB_TIMEOUT + 1 : 2;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    cmd_valid  = 1'b1;
    cmd_exec   = ex;
    cmd_data   = d;
    cmd_op     = op;
    a_ready_en = !(to_push && a_stall > 0);
    rsp_ready  = (rsp_stall == 0);
    @(negedge clk);
    check("cmd_ready in idle", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("cmd_ready busy", 32'(cmd_ready), 32'd0);
      if (rej) check("alu quiet on reject", 32'({a_valid, b_ready}), 32'd0);
      if (to_push && lat <= a_stall) begin
        check("a_valid held", 32'(a_valid), 32'd1);
        check("a_operand held", 32'(a_operand), 32'(d));
        check("b_ready idle in push", 32'(b_ready), 32'd0);
        if (lat == a_stall) a_ready_en = 1'b1;
      end
    end while (!rsp_valid && lat < 200);
    check("response latency", 32'(lat), 32'(exp_lat));

    if (rsp_stall > 0) begin
      repeat (rsp_stall) begin
        check("rsp_valid held", 32'(rsp_valid), 32'd1);
        check("rsp_result held", 32'(rsp_result), 32'(e.result));
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
    end

    lat = 0;
    while (rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("response consumed", 32'(rsp_valid), 32'd0);
    a_ready_en = 1'b1;
  endtask

  // Hard stop if anything hangs
  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_exec   = 1'b0;
    cmd_data   = '0;
    cmd_op     = '0;
    rsp_ready  = 1'b1;
    a_ready_en = 1'b1;
    b_valid_en = 1'b1;

    #2;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Two pushes then ADD2; occupancy ends at one
    send(1'b0, 8'h10, OP_ADD2, 0, 0, 1'b0);
    send(1'b0, 8'h05, OP_ADD2, 0, 0, 1'b0);
    send(1'b1, 8'h00, OP_ADD2, 0, 0, 1'b0);
    send(1'b1, 8'h00, OP_ADD2, 0, 0, 1'b0);
    send(1'b1, 8'h00, OP_AND,  0, 0, 1'b0);

    // Underflow on an empty FIFO
    send(1'b1, 8'h00, OP_SUB2, 0, 0, 1'b0);

    // Fill, overflow, SUM, then drain
    for (int i = 0; i < TB_DEPTH + 1; i++) send(1'b0, 8'hFF, OP_ADD2, 0, 0, 1'b0);
    send(1'b1, 8'h00, OP_SUM, 0, 0, 1'b0);
    for (int i = 0; i < TB_DEPTH - 1; i++) send(1'b1, 8'h00, OP_OR, 0, 0, 1'b0);

    // AVG with the host stalling the response
    send(1'b0, 8'h03, OP_ADD2, 0, 0, 1'b0);
    send(1'b0, 8'h04, OP_ADD2, 0, 0, 1'b0);
    send(1'b0, 8'h05, OP_ADD2, 0, 0, 1'b0);
    send(1'b1, 8'h00, OP_AVG, 0, 5, 1'b0);

    // ALU operand side stalled for four cycles
    send(1'b0, 8'h3C, OP_ADD2, 4, 0, 1'b0);

    // Random commands with random stalls
    for (int i = 0; i < 60; i++) begin
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
           $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end

    // Reset while an execute is waiting on the ALU
    send(1'b0, 8'h5A, OP_ADD2, 0, 0, 1'b0);
    b_valid_en = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_exec  = 1'b1;
    cmd_op    = OP_OR;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b_ready in exec", 32'(b_ready), 32'd1);
    check("b_operation in exec", 32'(b_operation), 32'(OP_OR));
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async reset");
    ref_q.delete();
    exp_q.delete();
    b_valid_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(1'b1, 8'h00, OP_AND2, 0, 0, 1'b0);
    send(1'b0, 8'h81, OP_ADD2, 0, 0, 1'b0);
    send(1'b1, 8'h00, OP_AND,  0, 0, 1'b0);

`ifdef SPECIAL_ALU_MASTER_TIMEOUT_EN
    // Execute with no ALU result: watchdog fires, occupancy unchanged
    send(1'b0, 8'h22, OP_ADD2, 0, 0, 1'b0);
    b_valid_en = 1'b0;
    send(1'b1, 8'h00, OP_SUM, 0, 0, 1'b1);
    b_valid_en = 1'b1;
    send(1'b1, 8'h00, OP_SUM, 0, 0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
